// File: rtl/carregador_instrucoes.sv
// rtl/carregador_instrucoes.sv - program loader: packs a byte stream into 32-bit words for the instruction memory
module carregador_instrucoes #(
    parameter int          NUM_WORDS = 13,
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int          CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iniciar,
    input  logic             cancelar,
    input  logic [7:0]       byte_in,
    input  logic             byte_valido,
    output logic             byte_pronto,
    output logic             mem_we,
    output logic [31:0]      mem_endereco,
    output logic [31:0]      mem_dado,
    output logic             ocupado,
    output logic             concluido,
    output logic [CNT_W-1:0] palavras_escritas
);

    typedef enum logic [1:0] {IDLE, RECEBE, ESCREVE, FIM} estado_t;

    localparam logic [CNT_W-1:0] ULTIMA = CNT_W'(NUM_WORDS);

    estado_t     estado, proximo;
    logic [1:0]  cont_bytes;
    logic [23:0] palavra;
    logic        aceita;

    always_comb begin
        proximo     = estado;
        byte_pronto = 1'b0;
        mem_we      = 1'b0;
        ocupado     = 1'b0;
        concluido   = 1'b0;
        aceita      = 1'b0;
        case (estado)
            IDLE: begin
                if (iniciar) proximo = RECEBE;
            end
            RECEBE: begin
                byte_pronto = 1'b1;
                ocupado     = 1'b1;
                // cancel wins over a byte offered on the same edge
                if (cancelar) begin
                    proximo = IDLE;
                end else if (byte_valido) begin
                    aceita = 1'b1;
                    if (cont_bytes == 2'd3) proximo = ESCREVE;
                end
            end
            ESCREVE: begin
                mem_we  = 1'b1;
                ocupado = 1'b1;
                proximo = (palavras_escritas + CNT_W'(1) == ULTIMA) ? FIM : RECEBE;
            end
            FIM: begin
                concluido = 1'b1;
                if (iniciar) proximo = RECEBE;
            end
            default: proximo = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado            <= IDLE;
            cont_bytes        <= 2'd0;
            palavra           <= 24'd0;
            palavras_escritas <= '0;
            mem_endereco      <= BASE_ADDR;
            mem_dado          <= 32'd0;
        end else begin
            estado <= proximo;
            if (aceita) begin
                palavra    <= {palavra[15:0], byte_in};
                cont_bytes <= cont_bytes + 2'd1;
                // address/data are latched with the 4th byte so they hold between strobes
                if (cont_bytes == 2'd3) begin
                    mem_dado     <= {palavra, byte_in};
                    mem_endereco <= BASE_ADDR + (32'(palavras_escritas) << 2);
                end
            end
            if (estado == RECEBE && cancelar) begin
                palavra    <= 24'd0;
                cont_bytes <= 2'd0;
            end
            if (estado == ESCREVE) begin
                palavras_escritas <= palavras_escritas + CNT_W'(1);
            end
            if ((estado == IDLE || estado == FIM) && iniciar) begin
                palavra           <= 24'd0;
                cont_bytes        <= 2'd0;
                palavras_escritas <= '0;
            end
        end
    end

endmodule

// File: tb/tb_carregador_instrucoes.sv
// tb/tb_carregador_instrucoes.sv - directed self-checking bench for carregador_instrucoes
module tb_carregador_instrucoes;

    logic        clk = 1'b0;
    logic        reset, iniciar, cancelar, byte_valido;
    logic [7:0]  byte_in;
    logic        byte_pronto, mem_we, ocupado, concluido;
    logic [31:0] mem_endereco, mem_dado;
    logic [7:0]  palavras_escritas;

    int total = 0;
    int bad   = 0;
    int wr_total = 0;
    logic [31:0] cap_addr [0:63];
    logic [31:0] cap_data [0:63];

    carregador_instrucoes #(.NUM_WORDS(13), .BASE_ADDR(32'd0), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .iniciar(iniciar), .cancelar(cancelar),
        .byte_in(byte_in), .byte_valido(byte_valido), .byte_pronto(byte_pronto),
        .mem_we(mem_we), .mem_endereco(mem_endereco), .mem_dado(mem_dado),
        .ocupado(ocupado), .concluido(concluido), .palavras_escritas(palavras_escritas)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we && wr_total < 64) begin
            cap_addr[wr_total] <= mem_endereco;
            cap_data[wr_total] <= mem_dado;
        end
        if (mem_we) wr_total <= wr_total + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_iniciar();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_in     = b;
        byte_valido = 1'b1;
        forever begin
            @(negedge clk);
            if (byte_pronto) break;
            n++;
            if (n > 50) begin
                check("send_byte_timeout", 32'(byte_pronto), 32'd1);
                break;
            end
        end
        tick();
        byte_valido = 1'b0;
    endtask

    function automatic logic [7:0] prog_byte(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    initial begin
        int base;
        logic [31:0] w;
        reset = 1'b1; iniciar = 1'b0; cancelar = 1'b0; byte_valido = 1'b0; byte_in = 8'd0;

        // 1: reset values
        repeat (2) tick();
        check("rst_pronto", 32'(byte_pronto), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_ocupado", 32'(ocupado), 32'd0);
        check("rst_concluido", 32'(concluido), 32'd0);
        check("rst_palavras", 32'(palavras_escritas), 32'd0);
        check("rst_end", mem_endereco, 32'd0);
        reset = 1'b0;
        tick();

        // 2: first word, write strobe the cycle after byte 4
        pulse_iniciar();
        check("t2_ocupado", 32'(ocupado), 32'd1);
        base = wr_total;
        send_byte(8'h00); send_byte(8'h50); send_byte(8'h00); send_byte(8'h93);
        @(negedge clk);
        check("t2_we", 32'(mem_we), 32'd1);
        check("t2_end", mem_endereco, 32'd0);
        check("t2_dado", mem_dado, 32'h0050_0093);
        check("t2_pronto", 32'(byte_pronto), 32'd0);
        tick();
        check("t2_pronto_again", 32'(byte_pronto), 32'd1);
        check("t2_count", 32'(wr_total - base), 32'd1);
        check("t2_palavras", 32'(palavras_escritas), 32'd1);

        // 3: full 13-word load with random gaps
        reset = 1'b1; tick(); reset = 1'b0;
        pulse_iniciar();
        base = wr_total;
        for (int i = 0; i < 52; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_byte(prog_byte(i));
        end
        tick(); tick();
        check("t3_count", 32'(wr_total - base), 32'd13);
        for (int k = 0; k < 13; k++) begin
            w = {prog_byte(4*k), prog_byte(4*k+1), prog_byte(4*k+2), prog_byte(4*k+3)};
            check("t3_addr", cap_addr[base + k], 32'(4 * k));
            check("t3_data", cap_data[base + k], w);
        end
        check("t3_concluido", 32'(concluido), 32'd1);
        check("t3_ocupado", 32'(ocupado), 32'd0);
        check("t3_palavras", 32'(palavras_escritas), 32'd13);
        byte_valido = 1'b1; byte_in = 8'hEE;
        repeat (3) begin
            @(negedge clk);
            check("t3_fim_pronto", 32'(byte_pronto), 32'd0);
        end
        tick();
        byte_valido = 1'b0;
        check("t3_fim_nowrite", 32'(wr_total - base), 32'd13);
        check("t3_fim_concluido", 32'(concluido), 32'd1);

        // 6b: iniciar in FIM restarts the load
        pulse_iniciar();
        check("t6_concluido", 32'(concluido), 32'd0);
        check("t6_palavras", 32'(palavras_escritas), 32'd0);
        check("t6_pronto", 32'(byte_pronto), 32'd1);

        // 4: cancel a partial word
        base = wr_total;
        send_byte(8'h11); send_byte(8'h22);
        cancelar = 1'b1; tick(); cancelar = 1'b0;
        check("t4_ocupado", 32'(ocupado), 32'd0);
        check("t4_pronto", 32'(byte_pronto), 32'd0);
        check("t4_concluido", 32'(concluido), 32'd0);
        tick();
        check("t4_nowrite", 32'(wr_total - base), 32'd0);

        // 4/6a: fresh load; iniciar during RECEBE is ignored
        pulse_iniciar();
        send_byte(8'hAA); send_byte(8'hBB);
        pulse_iniciar();
        check("t6_recebe_ocupado", 32'(ocupado), 32'd1);
        check("t6_recebe_palavras", 32'(palavras_escritas), 32'd0);
        send_byte(8'hCC); send_byte(8'hDD);
        tick();
        check("t4_count", 32'(wr_total - base), 32'd1);
        check("t4_addr", cap_addr[base], 32'd0);
        check("t4_data", cap_data[base], 32'hAABB_CCDD);
        check("t4_palavras", 32'(palavras_escritas), 32'd1);

        // 5: reset mid-word 5
        for (int i = 0; i < 16; i++) send_byte(prog_byte(i));
        tick();
        check("t5_palavras", 32'(palavras_escritas), 32'd5);
        check("t5_addr_w4", cap_addr[base + 4], 32'd16);
        base = wr_total;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        reset = 1'b1; tick(); reset = 1'b0;
        check("t5_we", 32'(mem_we), 32'd0);
        check("t5_pronto", 32'(byte_pronto), 32'd0);
        check("t5_ocupado", 32'(ocupado), 32'd0);
        check("t5_palavras0", 32'(palavras_escritas), 32'd0);
        check("t5_end", mem_endereco, 32'd0);
        check("t5_dado", mem_dado, 32'd0);
        tick(); tick();
        check("t5_nowrite", 32'(wr_total - base), 32'd0);
        pulse_iniciar();
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        tick();
        check("t5_restart_count", 32'(wr_total - base), 32'd1);
        check("t5_restart_addr", cap_addr[base], 32'd0);
        check("t5_restart_data", cap_data[base], 32'h1234_5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
